// File: rtl/ex_muldiv_unit_if.sv
// EX-stage mul/div request/response bundle between pipeline and the iterative unit.
interface ex_muldiv_unit_if #(parameter int unsigned XLEN = 64);
  logic            valid_i;
  logic [3:0]      op_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            stall_req_o;
  logic [XLEN-1:0] result_o;
  logic            result_valid_o;

  modport master (
    output valid_i, op_i, rs1_i, rs2_i, flush_i,
    input  stall_req_o, result_o, result_valid_o
  );

  modport slave (
    input  valid_i, op_i, rs1_i, rs2_i, flush_i,
    output stall_req_o, result_o, result_valid_o
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative RV64M multiply/divide unit: shift-add MUL and restoring DIV, one bit per cycle.
module ex_muldiv_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic             clk,
  input  logic             rst,
  ex_muldiv_unit_if.slave  bus
);
  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN) + 1;
  localparam int unsigned HW = 32;
  localparam int unsigned EW = XLEN - HW;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic            load, step;
  logic [CW-1:0]   cnt;
  logic            is_w_q, is_div_q, neg_q, neg_rem_q;
  logic [1:0]      fn_q;
  logic [PW-1:0]   acc_q, opb_q;
  logic [XLEN-1:0] opa_q;
  logic [XLEN-1:0] result_q;
  logic            result_valid_q;

  logic            is_w, is_div, a_sgn, b_sgn, a_neg, b_neg, div0, ovf, special;
  logic [XLEN-1:0] a_eff, b_eff, a_mag, b_mag, min_eff, spec_raw, spec_res;

  logic [PW-1:0]   acc_n, opb_n, prod_s;
  logic [XLEN-1:0] opa_n, quo_s, rem_s, iter_raw, iter_res;
  logic [XLEN:0]   sh, diff;

  // Operand decode: effective operands, magnitudes, sign fix-ups and special-case results
  always_comb begin
    is_w   = bus.op_i[3];
    is_div = bus.op_i[2];
    if (is_div) begin
      a_sgn = !bus.op_i[0];
      b_sgn = !bus.op_i[0];
    end else if (is_w) begin
      a_sgn = 1'b0;
      b_sgn = 1'b0;
    end else begin
      a_sgn = !(bus.op_i[1] && bus.op_i[0]);
      b_sgn = !bus.op_i[1];
    end
    a_eff = bus.rs1_i;
    b_eff = bus.rs2_i;
    if (is_w) begin
      a_eff = {{EW{a_sgn & bus.rs1_i[HW-1]}}, bus.rs1_i[HW-1:0]};
      b_eff = {{EW{b_sgn & bus.rs2_i[HW-1]}}, bus.rs2_i[HW-1:0]};
    end
    a_neg   = a_sgn & a_eff[XLEN-1];
    b_neg   = b_sgn & b_eff[XLEN-1];
    a_mag   = a_neg ? -a_eff : a_eff;
    b_mag   = b_neg ? -b_eff : b_eff;
    min_eff = is_w ? {{(EW + 1){1'b1}}, {(HW - 1){1'b0}}} : {1'b1, {(XLEN - 1){1'b0}}};
    div0    = is_div && (b_eff == '0);
    ovf     = is_div && a_sgn && (a_eff == min_eff) && (b_eff == '1);
    special = div0 || ovf;
    if (bus.op_i[1]) spec_raw = div0 ? a_eff : '0;
    else             spec_raw = div0 ? '1 : a_eff;
    spec_res = is_w ? {{EW{spec_raw[HW-1]}}, spec_raw[HW-1:0]} : spec_raw;
  end

  // One iteration of the datapath plus the signed/W-adjusted result it would yield
  always_comb begin
    sh   = {acc_q[XLEN-1:0], opa_q[XLEN-1]};
    diff = sh - {1'b0, opb_q[XLEN-1:0]};
    if (is_div_q) begin
      acc_n = PW'(diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]);
      opa_n = {opa_q[XLEN-2:0], !diff[XLEN]};
      opb_n = opb_q;
    end else begin
      acc_n = acc_q + (opa_q[0] ? opb_q : '0);
      opa_n = opa_q >> 1;
      opb_n = opb_q << 1;
    end
    prod_s = neg_q ? -acc_n : acc_n;
    quo_s  = neg_q ? -opa_n : opa_n;
    rem_s  = neg_rem_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    if (is_div_q) iter_raw = fn_q[1] ? rem_s : quo_s;
    else          iter_raw = (fn_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[PW-1:XLEN];
    iter_res = is_w_q ? {{EW{iter_raw[HW-1]}}, iter_raw[HW-1:0]} : iter_raw;
  end

  // Next-state logic; flush or a dropped valid aborts without a strobe
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid_i && !bus.flush_i) begin
          load      = 1'b1;
          state_nxt = special ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (bus.flush_i || !bus.valid_i) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == (is_w_q ? CW'(HW - 1) : CW'(XLEN - 1))) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered result/strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      is_w_q         <= 1'b0;
      is_div_q       <= 1'b0;
      neg_q          <= 1'b0;
      neg_rem_q      <= 1'b0;
      fn_q           <= '0;
      acc_q          <= '0;
      opa_q          <= '0;
      opb_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state          <= state_nxt;
      result_valid_q <= (state_nxt == DONE);
      if (state_nxt == DONE) result_q <= (state == IDLE) ? spec_res : iter_res;
      if (load) begin
        cnt       <= '0;
        is_w_q    <= is_w;
        is_div_q  <= is_div;
        fn_q      <= bus.op_i[1:0];
        neg_q     <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
        acc_q     <= '0;
        if (is_div) begin
          opa_q <= is_w ? (a_mag << HW) : a_mag;
          opb_q <= PW'(b_mag);
        end else begin
          opa_q <= b_mag;
          opb_q <= PW'(a_mag);
        end
      end else if (step) begin
        cnt   <= cnt + CW'(1);
        acc_q <= acc_n;
        opa_q <= opa_n;
        opb_q <= opb_n;
      end
    end
  end

  assign bus.stall_req_o    = bus.valid_i && !bus.flush_i && (state != DONE);
  assign bus.result_o       = result_q;
  assign bus.result_valid_o = result_valid_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit with an expected-result queue.
module tb_ex_muldiv_unit;
  localparam int unsigned XLEN = 64;

  logic clk = 1'b0;
  logic rst;

  ex_muldiv_unit_if #(.XLEN(XLEN)) bus ();

  ex_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int strobes = 0;
  logic [XLEN-1:0] exp_q[$];

  // Free-running cycle counter and strobe monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.result_valid_o) strobes <= strobes + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op at the start of a cycle; checks latency, stall window, result
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int lat, output int done_cyc);
    int k;
    int st;
    logic [XLEN-1:0] want;
    bus.valid_i = 1'b1;
    bus.op_i    = op;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    exp_q.push_back(exp);
    #1;
    st = bus.stall_req_o ? 1 : 0;
    k  = 0;
    while (k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.result_valid_o) break;
      if (bus.stall_req_o) st++;
    end
    done_cyc = cyc;
    want = exp_q.pop_front();
    chk({tag, "_valid"}, XLEN'(bus.result_valid_o), XLEN'(1));
    chk({tag, "_lat"}, XLEN'(k), XLEN'(lat));
    chk({tag, "_stall"}, XLEN'(st), XLEN'(lat));
    chk({tag, "_stall_done"}, XLEN'(bus.stall_req_o), XLEN'(0));
    chk({tag, "_res"}, bus.result_o, want);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    chk({tag, "_one_strobe"}, XLEN'(bus.result_valid_o), XLEN'(0));
  endtask

  initial begin
    int d0, d1, t0, s0;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.op_i    = '0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;
    bus.flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result_o, '0);
    chk("rst_valid", XLEN'(bus.result_valid_o), XLEN'(0));
    chk("rst_stall", XLEN'(bus.stall_req_o), XLEN'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Multiplies
    run_op("mul",     4'b0000, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 65, d0);
    run_op("mulhu",   4'b0011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, d0);
    run_op("mulh",    4'b0001, '1, '1, 64'h0, 65, d0);
    run_op("mulhsu1", 4'b0010, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, d0);
    run_op("mulhsu2", 4'b0010, 64'd2, '1, 64'h1, 65, d0);
    run_op("mulw",    4'b1000, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33, d0);

    // Divides
    run_op("div",   4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, d0);
    run_op("rem",   4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, d0);
    run_op("divu",  4'b0101, '1, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 65, d0);
    run_op("remu",  4'b0111, 64'd100, 64'd7, 64'd2, 65, d0);
    run_op("divuw", 4'b1101, 64'h1_0000_000A, 64'd3, 64'd3, 33, d0);
    run_op("divw",  4'b1100, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33, d0);
    run_op("remw",  4'b1110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, d0);

    // Special cases resolve in one cycle
    run_op("div0",    4'b0100, 64'd42, 64'd0, '1, 1, d0);
    run_op("rem0",    4'b0110, 64'd42, 64'd0, 64'd42, 1, d0);
    run_op("divu0",   4'b0101, 64'd42, 64'd0, '1, 1, d0);
    run_op("remu0",   4'b0111, 64'd42, 64'd0, 64'd42, 1, d0);
    run_op("divuw0",  4'b1101, 64'h8000_0000, 64'h1_0000_0000, '1, 1, d0);
    run_op("remuw0",  4'b1111, 64'h8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000, 1, d0);
    run_op("divovf",  4'b0100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1, d0);
    run_op("removf",  4'b0110, 64'h8000_0000_0000_0000, '1, 64'h0, 1, d0);
    run_op("divwovf", 4'b1100, 64'h8000_0000, '1, 64'hFFFF_FFFF_8000_0000, 1, d0);
    run_op("remwovf", 4'b1110, 64'h8000_0000, '1, 64'h0, 1, d0);

    // Flush in BUSY cycle 10: no strobe, result held
    run_op("pre_flush", 4'b0101, 64'd1000, 64'd10, 64'd100, 65, d0);
    s0 = strobes;
    bus.valid_i = 1'b1;
    bus.op_i    = 4'b0101;
    bus.rs1_i   = 64'd100;
    bus.rs2_i   = 64'd7;
    repeat (10) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    chk("flush_stall", XLEN'(bus.stall_req_o), XLEN'(0));
    @(posedge clk);
    #1;
    bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    chk("flush_valid", XLEN'(bus.result_valid_o), XLEN'(0));
    chk("flush_hold", bus.result_o, 64'd100);
    repeat (70) @(posedge clk);
    #1;
    chk("flush_no_strobe", XLEN'(strobes), XLEN'(s0));
    chk("flush_hold2", bus.result_o, 64'd100);
    run_op("post_flush", 4'b0101, 64'd100, 64'd7, 64'd14, 65, d0);

    // Back-to-back DIVU
    t0 = cyc;
    run_op("b2b_a", 4'b0101, 64'd100, 64'd7, 64'd14, 65, d0);
    run_op("b2b_b", 4'b0101, 64'd9, 64'd3, 64'd3, 65, d1);
    chk("b2b_t1", XLEN'(d0 - t0), XLEN'(65));
    chk("b2b_t2", XLEN'(d1 - t0), XLEN'(131));

    // Reset mid-BUSY
    bus.valid_i = 1'b1;
    bus.op_i    = 4'b0000;
    bus.rs1_i   = 64'd5;
    bus.rs2_i   = 64'd6;
    repeat (20) @(posedge clk);
    #1;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    @(posedge clk);
    #1;
    chk("rstb_result", bus.result_o, '0);
    chk("rstb_valid", XLEN'(bus.result_valid_o), XLEN'(0));
    chk("rstb_stall", XLEN'(bus.stall_req_o), XLEN'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_op("post_rst", 4'b0000, 64'd5, 64'd6, 64'd30, 65, d0);
    chk("queue_empty", XLEN'(exp_q.size()), XLEN'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
